// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep scheduler: channel count,
// command codes on the 4-bit ctrl channel and the FSM state encoding.
package sonar_pkg;

  // Number of sonar channels; the channel id is 3 bits, so at most 8.
  localparam int NCH = 6;

  // Command codes carried on cfg_ctrl.
  localparam logic [3:0] CMD_MASK    = 4'd0;
  localparam logic [3:0] CMD_TIMEOUT = 4'd1;
  localparam logic [3:0] CMD_GUARD   = 4'd2;
  localparam logic [3:0] CMD_SWEEP   = 4'd3;
  localparam logic [3:0] CMD_TOCLR   = 4'd4;

  // Scheduler states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

endpackage

// File: rtl/sonar_next_ch.sv
// Round-robin channel picker: returns the lowest set mask bit strictly
// above cur_ch, or, when there is none, the lowest set bit overall with
// wrap raised. Passing cur_ch = NCH-1 therefore yields the lowest set bit.
module sonar_next_ch import sonar_pkg::*; #(
  parameter int NCH = sonar_pkg::NCH
) (
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     cur_ch,
  output logic [2:0]     next_ch,
  output logic           wrap
);

  logic [2:0] above;
  logic [2:0] lowest;
  logic       has_above;

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise a
    // path that assigns nothing would infer a latch.
    above     = '0;
    lowest    = '0;
    has_above = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = 3'(i);
        if (3'(i) > cur_ch) begin
          above     = 3'(i);
          has_above = 1'b1;
        end
      end
    end
    wrap    = !has_above;
    next_ch = has_above ? above : lowest;
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Sonar sweep scheduler: fires HC04 channels one at a time in round-robin
// order over an enable mask, waits for each result or a timeout, then
// holds a guard gap before the next trigger.
// Optional build macro SONAR_SCHED_TIMEOUT_CNT_EN adds timeout statistics
// (to_cnt, to_stb, to_ch) and the CMD_TOCLR command.
module sonar_scheduler import sonar_pkg::*; #(
  parameter int                 NCH         = sonar_pkg::NCH,
  parameter int                 TO_W        = 20,
  parameter int                 GUARD_W     = 16,
  parameter logic [TO_W-1:0]    DEF_TIMEOUT = 20'd600000,
  parameter logic [GUARD_W-1:0] DEF_GUARD   = 16'd5000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     cfg_ctrl,
  input  logic [23:0]    cfg_data,
  input  logic           cfg_wr,
  output logic [NCH-1:0] son_trig,
  output logic           son_wr,
  input  logic           res_stb,
  input  logic [2:0]     res_ch,
  output logic           busy,
  output logic [2:0]     cur_ch,
  output logic           sweep_done
`ifdef SONAR_SCHED_TIMEOUT_CNT_EN
  ,
  output logic [15:0]    to_cnt,
  output logic           to_stb,
  output logic [2:0]     to_ch
`endif
);

  logic [1:0]         state;
  logic [NCH-1:0]     mask;
  logic               run;
  logic               start_req;
  logic [TO_W-1:0]    timeout;
  logic [TO_W-1:0]    to_eff;
  logic [TO_W-1:0]    cnt;
  logic [GUARD_W-1:0] guard;
  logic [GUARD_W-1:0] guard_eff;
  logic [GUARD_W-1:0] gcnt;
  logic [2:0]         nxt_ch;
  logic               nxt_wrap;
  logic [2:0]         low_ch;
  logic               unused_low_wrap;
  logic               unused_data;
  logic               hit;
  logic               to_evt;
  logic               guard_end;
  logic               start;

  // Only the low payload bits carry meaning for any command.
  assign unused_data = ^cfg_data;

  // Next channel above cur_ch (wraps to the lowest bit) and lowest set bit.
  sonar_next_ch #(.NCH(NCH)) u_next (
    .mask    (mask),
    .cur_ch  (cur_ch),
    .next_ch (nxt_ch),
    .wrap    (nxt_wrap)
  );

  sonar_next_ch #(.NCH(NCH)) u_low (
    .mask    (mask),
    .cur_ch  (3'(NCH - 1)),
    .next_ch (low_ch),
    .wrap    (unused_low_wrap)
  );

  // A zero timeout or guard behaves as one cycle; both compare live values,
  // and >= keeps a value lowered mid-wait from being skipped past.
  assign to_eff    = (timeout == '0) ? TO_W'(1) : timeout;
  assign guard_eff = (guard == '0) ? GUARD_W'(1) : guard;

  // A matching result beats a timeout expiring in the same cycle.
  assign hit       = (state == ST_WAIT) && res_stb && (res_ch == cur_ch);
  assign to_evt    = (state == ST_WAIT) && !hit && (cnt >= to_eff - TO_W'(1));
  assign guard_end = (state == ST_GUARD) && (gcnt >= guard_eff - GUARD_W'(1));
  assign start     = (state == ST_IDLE) && (run || start_req) && (|mask);

  assign son_wr     = (state == ST_FIRE);
  assign son_trig   = son_wr ? (NCH'(1) << cur_ch) : '0;
  assign busy       = (state != ST_IDLE);
  assign sweep_done = guard_end && nxt_wrap;

  // Configuration registers and the one-shot sweep request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '0;
      run       <= 1'b0;
      timeout   <= DEF_TIMEOUT;
      guard     <= DEF_GUARD;
      start_req <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      start_req <= cfg_wr && (cfg_ctrl == CMD_SWEEP) && (state == ST_IDLE);
      if (cfg_wr) begin
        case (cfg_ctrl)
          CMD_MASK: begin
            mask <= cfg_data[NCH-1:0];
            run  <= cfg_data[8];
          end
          CMD_TIMEOUT: timeout <= cfg_data[TO_W-1:0];
          CMD_GUARD:   guard   <= cfg_data[GUARD_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Sweep sequencer: IDLE -> FIRE -> WAIT -> GUARD -> FIRE/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur_ch <= '0;
      cnt    <= '0;
      gcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_ch <= low_ch;
            state  <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + TO_W'(1);
          if (hit || to_evt) begin
            gcnt  <= '0;
            state <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guard_end) begin
            if (!nxt_wrap) begin
              cur_ch <= nxt_ch;
              state  <= ST_FIRE;
            end else if (run && (|mask)) begin
              cur_ch <= low_ch;
              state  <= ST_FIRE;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gcnt <= gcnt + GUARD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SONAR_SCHED_TIMEOUT_CNT_EN
  // Timeout statistics: saturating count, strobe and last timed-out channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_stb <= 1'b0;
      to_ch  <= '0;
    end else begin
      to_stb <= to_evt;
      if (to_evt) to_ch <= cur_ch;
      if (cfg_wr && (cfg_ctrl == CMD_TOCLR)) to_cnt <= '0;
      else if (to_evt && (to_cnt != '1)) to_cnt <= to_cnt + 16'd1;
    end
  end
`endif

endmodule
